// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: scrambler polynomial taps, sync header
// codes and the block word-position encoding. Used by both the TX scrambler
// and the RX descrambler.
package pcs_pkg;

  // G(x) = 1 + x^39 + x^58, taps expressed as indices into a 58-bit history
  localparam int LFSR_WIDTH = 58;
  localparam int TAP_A      = 38;
  localparam int TAP_B      = 57;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [0:0] {
    EXPECT_HDR = 1'b0,
    EXPECT_W1  = 1'b1
  } blk_pos_t;

  // Only 01 and 10 are legal sync headers; 00 and 11 indicate corruption
  function automatic logic is_valid_sync(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/descrambler_lfsr_step.sv
// Combinational self-synchronizing descrambler step over one payload word.
// Bit 0 is processed first; the received (scrambled) bit is what enters the
// history, so any 58 consecutive correct input bits resynchronize the state.
module descrambler_lfsr_step
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [LFSR_WIDTH-1:0] state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_next,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [LFSR_WIDTH-1:0] s_work;

  // Unroll the serial descrambler across the word, bit 0 first
  always_comb begin
    s_work   = state;
    data_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data_out[i] = data_in[i] ^ s_work[TAP_A] ^ s_work[TAP_B];
      s_work      = {s_work[LFSR_WIDTH-2:0], data_in[i]};
    end
    state_next = s_work;
  end

endmodule

// File: rtl/descrambler.sv
// 10GBASE-R receive descrambler (inverse of 1 + x^39 + x^58).
// Takes two 32-bit payload words per 66-bit block, header on the first word,
// and produces descrambled payload one cycle later together with priming,
// header-error and word-sequencing flags.
// Build option: define DESCRAMBLER_ERR_CNT_EN to include a saturating 16-bit
// header error counter on o_hdr_err_cnt; otherwise that port is tied to zero.
//
// Word position FSM
//   state      | meaning
//   EXPECT_HDR | next accepted word should carry a sync header
//   EXPECT_W1  | header word seen, next accepted word is the second payload word
module descrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,  // only 32 supported (2 words per block)
  parameter int DESCRAMBLER_BYPASS = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_block_lock,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_hdr_valid,
  input  logic [1:0]            i_hdr,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_hdr_valid,
  output logic [1:0]            o_hdr,
  output logic                  o_primed,
  output logic                  o_hdr_err,
  output logic                  o_seq_err,
  output logic [15:0]           o_hdr_err_cnt
);

  localparam logic [0:0] ST_EXPECT_HDR = EXPECT_HDR;
  localparam logic [0:0] ST_EXPECT_W1  = EXPECT_W1;

  logic                  accept;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [DATA_WIDTH-1:0] desc_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            prime_cnt;
  logic [0:0]            pos;
  logic                  hdr_err_next;
  logic                  seq_err_next;

  // A word is only trusted while block lock is held
  assign accept = i_data_valid & i_block_lock;

  descrambler_lfsr_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .state      (lfsr),
    .data_in    (i_data),
    .state_next (lfsr_next),
    .data_out   (desc_data)
  );

  // Bypass keeps the LFSR and all flags running; only the payload is untouched
  assign out_data = (DESCRAMBLER_BYPASS != 0) ? i_data : desc_data;

  // Header legality and position checks for the word being accepted
  always_comb begin
    hdr_err_next = 1'b0;
    seq_err_next = 1'b0;
    if (accept) begin
      hdr_err_next = i_hdr_valid & ~is_valid_sync(i_hdr);
      if (i_hdr_valid)
        seq_err_next = (pos == ST_EXPECT_W1);
      else
        seq_err_next = (pos == ST_EXPECT_HDR);
    end
  end

  // Registered output stage; data and header hold between valid words
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_hdr_valid  <= 1'b0;
      o_hdr        <= 2'b00;
      o_hdr_err    <= 1'b0;
      o_seq_err    <= 1'b0;
    end else begin
      o_data_valid <= accept;
      o_hdr_err    <= hdr_err_next;
      o_seq_err    <= seq_err_next;
      if (accept) begin
        o_data      <= out_data;
        o_hdr_valid <= i_hdr_valid;
        o_hdr       <= i_hdr;
      end
    end
  end

  // LFSR history advances on accepted words only; lock loss does not clear it
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      lfsr <= '0;
    else if (accept)
      lfsr <= lfsr_next;
  end

  // Saturating count of accepted words since lock; two words fill the history
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_block_lock)
      prime_cnt <= 2'd0;
    else if (accept && prime_cnt != 2'd3)
      prime_cnt <= prime_cnt + 2'd1;
  end

  assign o_primed = prime_cnt[1];

  // Block word-position FSM; a header word always (re)starts a block
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_block_lock)
      pos <= ST_EXPECT_HDR;
    else if (accept) begin
      if (i_hdr_valid)
        pos <= ST_EXPECT_W1;
      else
        pos <= ST_EXPECT_HDR;
    end
  end

`ifdef DESCRAMBLER_ERR_CNT_EN
  logic [15:0] hdr_err_cnt;

  // Counts alongside the error pulse; survives lock loss, cleared by reset only
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      hdr_err_cnt <= 16'h0;
    else if (hdr_err_next && hdr_err_cnt != 16'hFFFF)
      hdr_err_cnt <= hdr_err_cnt + 16'h1;
  end

  assign o_hdr_err_cnt = hdr_err_cnt;
`else
  assign o_hdr_err_cnt = 16'h0;
`endif

endmodule
